// File: rtl/paint_scheduler.sv
// Front-end for the circle painter: round-robin arbitration of two command
// sources into a small FIFO, and one-at-a-time issue over the painter's valid/ready pins.
module paint_scheduler #(
  parameter int FIFO_DEPTH   = 4,
  parameter int MAX_RADIUS   = 64,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [1:0]                    req_valid_in,
  input  logic [10:0]                   req0_hcount_in,
  input  logic [10:0]                   req1_hcount_in,
  input  logic [9:0]                    req0_vcount_in,
  input  logic [9:0]                    req1_vcount_in,
  input  logic [16:0]                   req0_radius_in,
  input  logic [16:0]                   req1_radius_in,
  output logic [1:0]                    req_ready_out,
  input  logic                          painter_ready_in,
  output logic                          painter_valid_out,
  output logic [10:0]                   painter_hcount_out,
  output logic [9:0]                    painter_vcount_out,
  output logic [16:0]                   painter_radius_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out,
  output logic [7:0]                    drop_count_out,
  output logic                          busy_out
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [16:0] MAX_R = 17'(MAX_RADIUS);

  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
    logic [16:0] r;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          valid_q, valid_d;
  cmd_t          out_q, out_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    drop_q, drop_d;
  logic          last_grant_q, last_grant_d;
  cmd_t          mem_q [FIFO_DEPTH];

  cmd_t       req_cmd [2];
  cmd_t       in_cmd, push_cmd;
  logic [1:0] grant, xfer;
  logic       full, push_any, sel, is_drop, push, pop;

  assign req_cmd[0] = {req0_hcount_in, req0_vcount_in, req0_radius_in};
  assign req_cmd[1] = {req1_hcount_in, req1_vcount_in, req1_radius_in};

  // A lone requester always wins; on a tie the one that did not win last time goes.
  for (genvar gi = 0; gi < 2; gi++) begin : g_grant
    assign grant[gi] = req_valid_in[gi] &&
                       (!req_valid_in[1-gi] || (last_grant_q != 1'(gi)));
  end

  assign full          = (count_q == CW'(FIFO_DEPTH));
  assign req_ready_out = full ? 2'b00 : grant;
  assign xfer          = req_valid_in & req_ready_out;
  assign push_any      = |xfer;
  assign sel           = xfer[1];
  assign in_cmd        = req_cmd[sel];
  assign is_drop       = push_any && (in_cmd.r == '0);
  assign push          = push_any && !is_drop;
  assign pop           = (state_q == IDLE) && (count_q != '0) && painter_ready_in;

  always_comb begin
    push_cmd = in_cmd;
    if (in_cmd.r > MAX_R) push_cmd.r = MAX_R;
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    drop_d       = drop_q;
    last_grant_d = push_any ? sel : last_grant_q;
    count_d      = count_q + CW'(push) - CW'(pop);
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (is_drop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    valid_d = 1'b0;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          out_d   = mem_q[rd_ptr_q];
          valid_d = 1'b1;
          tmo_d   = '0;
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        // A painter that never drops ready has ignored the launch; give up on it.
        if (!painter_ready_in) begin
          state_d = WAIT_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if ((tmo_q + 1'b1) == TW'(BUSY_TIMEOUT)) state_d = IDLE;
        end
      end
      WAIT_DONE: begin
        if (painter_ready_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q] <= push_cmd;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      tmo_q        <= '0;
      valid_q      <= 1'b0;
      out_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      drop_q       <= '0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      valid_q      <= valid_d;
      out_q        <= out_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      drop_q       <= drop_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign painter_valid_out  = valid_q;
  assign painter_hcount_out = out_q.h;
  assign painter_vcount_out = out_q.v;
  assign painter_radius_out = out_q.r;
  assign fifo_count_out     = count_q;
  assign drop_count_out     = drop_q;
  assign busy_out           = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_paint_scheduler.sv
// Self-checking bench for paint_scheduler: directed tables and sequences, then
// random traffic against a transaction-level queue model with a painter model.
module tb_paint_scheduler;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [10:0] h0, h1;
  logic [9:0]  v0, v1;
  logic [16:0] r0, r1;
  logic [1:0]  req_ready;
  logic        p_rdy = 1'b0;
  logic        pv;
  logic [10:0] ph;
  logic [9:0]  pvc;
  logic [16:0] pr;
  logic [2:0]  fcnt;
  logic [7:0]  dcnt;
  logic        busy;

  paint_scheduler #(.FIFO_DEPTH(DEPTH), .MAX_RADIUS(64), .BUSY_TIMEOUT(8)) dut (
    .clk_in(clk), .rst_in(rst), .req_valid_in(req_valid),
    .req0_hcount_in(h0), .req1_hcount_in(h1),
    .req0_vcount_in(v0), .req1_vcount_in(v1),
    .req0_radius_in(r0), .req1_radius_in(r1),
    .req_ready_out(req_ready), .painter_ready_in(p_rdy),
    .painter_valid_out(pv), .painter_hcount_out(ph),
    .painter_vcount_out(pvc), .painter_radius_out(pr),
    .fifo_count_out(fcnt), .drop_count_out(dcnt), .busy_out(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [10:0] h; logic [9:0] v; logic [16:0] r; } pulse_t;
  typedef struct { logic [10:0] h; logic [9:0] v; logic [16:0] r; } cmd_t;
  typedef struct {
    logic [1:0] v; logic [16:0] r0; logic [16:0] r1;
    logic [1:0] rdy; int cnt; int drop;
  } vec_t;

  pulse_t pulse_q[$];
  int n_cmp = 0, n_bad = 0, cyc_n = 0, bad_launch = 0;

  // Painter: drops ready the edge after it sees valid, busy for p_busy_len cycles.
  logic p_hold = 1'b1, p_ignore = 1'b0;
  int   p_busy_len = 3, p_cnt = 0;
  always @(posedge clk) begin
    if (p_hold) begin
      p_rdy <= 1'b0;
      p_cnt <= 0;
    end else if (p_ignore) begin
      p_rdy <= 1'b1;
    end else if (p_rdy && pv) begin
      p_rdy <= 1'b0;
      p_cnt <= p_busy_len;
    end else if (!p_rdy) begin
      if (p_cnt <= 1) p_rdy <= 1'b1;
      else p_cnt <= p_cnt - 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_n++;
    if (pv === 1'b1) begin
      pulse_q.push_back('{cyc_n, ph, pvc, pr});
      if (p_rdy !== 1'b1) bad_launch++;
    end
  endtask

  task automatic set_req(input logic [1:0] v, input int a0, input int b0, input int c0,
                         input int a1, input int b1, input int c1);
    req_valid = v;
    h0 = 11'(a0); v0 = 10'(b0); r0 = 17'(c0);
    h1 = 11'(a1); v1 = 10'(b1); r1 = 17'(c1);
  endtask

  task automatic chk_pulse(input string name, input int idx, input int h, input int v, input int r);
    if (idx < pulse_q.size())
      chk(name, {pulse_q[idx].h, pulse_q[idx].v, pulse_q[idx].r}, {11'(h), 10'(v), 17'(r)});
    else
      chk({name, "_present"}, 64'(pulse_q.size()), 64'(idx + 1));
  endtask

  task automatic wait_idle(input int max);
    for (int i = 0; i < max && busy; i++) tick();
    chk("idle_reached", busy, 0);
  endtask

  vec_t tbl[8];
  cmd_t exp_q[$];

  initial begin
    // Painter held not ready; last_grant starts at 1 after reset.
    tbl[0] = '{2'b11, 17'd20,  17'd30,  2'b01, 1, 0};
    tbl[1] = '{2'b11, 17'd21,  17'd31,  2'b10, 2, 0};
    tbl[2] = '{2'b00, 17'd22,  17'd32,  2'b00, 2, 0};
    tbl[3] = '{2'b11, 17'd0,   17'd33,  2'b01, 2, 1};
    tbl[4] = '{2'b01, 17'd200, 17'd34,  2'b01, 3, 1};
    tbl[5] = '{2'b10, 17'd5,   17'd100, 2'b10, 4, 1};
    tbl[6] = '{2'b11, 17'd6,   17'd7,   2'b00, 4, 1};
    tbl[7] = '{2'b01, 17'd8,   17'd9,   2'b00, 4, 1};

    rst = 1'b1;
    set_req(2'b00, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", pv, 0);
    chk("rst_cmd", {ph, pvc, pr}, 0);
    chk("rst_count", fcnt, 0);
    chk("rst_drop", dcnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready_none", req_ready, 2'b00);
    set_req(2'b11, 1, 1, 1, 2, 2, 2);
    #1 chk("rst_tie_to_req0", req_ready, 2'b01);
    set_req(2'b00, 0, 0, 0, 0, 0, 0);

    // Table: arbitration, radius handling and the full FIFO with the painter stalled.
    for (int i = 0; i < 8; i++) begin
      set_req(tbl[i].v, 100 + i, 10 + i, int'(tbl[i].r0), 200 + i, 20 + i, int'(tbl[i].r1));
      #1 chk($sformatf("tbl%0d_ready", i), req_ready, tbl[i].rdy);
      tick();
      chk($sformatf("tbl%0d_count", i), fcnt, 64'(tbl[i].cnt));
      chk($sformatf("tbl%0d_drop", i), dcnt, 64'(tbl[i].drop));
      chk($sformatf("tbl%0d_busy", i), busy, 64'(tbl[i].cnt != 0));
    end

    // Release the painter: the push in the pop cycle is refused, then taken.
    pulse_q.delete();
    p_busy_len = 2;
    p_hold = 1'b0;
    set_req(2'b01, 300, 30, 40, 0, 0, 0);
    #1 chk("full_refuse", req_ready, 2'b00);
    tick();
    chk("pop_cycle_refuse", req_ready, 2'b00);
    chk("pop_cycle_count", fcnt, 4);
    tick();
    chk("first_issue_valid", pv, 1);
    chk("after_pop_count", fcnt, 3);
    chk("accept_after_pop", req_ready, 2'b01);
    tick();
    set_req(2'b00, 0, 0, 0, 0, 0, 0);
    chk("refill_count", fcnt, 4);
    for (int i = 0; i < 100 && !(pulse_q.size() >= 5 && !busy); i++) tick();
    chk("drain_issue_count", 64'(pulse_q.size()), 5);
    chk_pulse("drain0", 0, 100, 10, 20);
    chk_pulse("drain1", 1, 201, 21, 31);
    chk_pulse("drain2", 2, 104, 14, 64);
    chk_pulse("drain3", 3, 205, 25, 64);
    chk_pulse("drain4", 4, 300, 30, 40);

    // Single command: two cycles from push to the launch pulse.
    p_busy_len = 3;
    pulse_q.delete();
    set_req(2'b01, 640, 360, 20, 0, 0, 0);
    #1 chk("single_ready", req_ready, 2'b01);
    tick();
    set_req(2'b00, 0, 0, 0, 0, 0, 0);
    chk("single_count", fcnt, 1);
    chk("single_not_yet", pv, 0);
    chk("single_busy", busy, 1);
    tick();
    chk("single_valid", pv, 1);
    chk("single_cmd", {ph, pvc, pr}, {11'd640, 10'd360, 17'd20});
    tick();
    chk("single_one_cycle", pv, 0);
    chk("single_hold_cmd", {ph, pvc, pr}, {11'd640, 10'd360, 17'd20});
    for (int i = 0; i < 12; i++) tick();
    chk("single_busy_fall", busy, 0);
    chk("single_issue_count", 64'(pulse_q.size()), 1);

    // Back-to-back: second launch waits for ready to fall and re-rise.
    pulse_q.delete();
    set_req(2'b01, 10, 11, 12, 0, 0, 0);
    tick();
    set_req(2'b10, 0, 0, 0, 20, 21, 22);
    tick();
    set_req(2'b00, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 40 && pulse_q.size() < 2; i++) tick();
    chk_pulse("b2b_first", 0, 10, 11, 12);
    chk_pulse("b2b_second", 1, 20, 21, 22);
    if (pulse_q.size() == 2) chk("b2b_gap", 64'(pulse_q[1].cyc - pulse_q[0].cyc), 64'(p_busy_len + 3));
    wait_idle(30);

    // Timeout: the painter keeps ready high and never acknowledges.
    p_ignore = 1'b1;
    pulse_q.delete();
    set_req(2'b01, 400, 40, 5, 0, 0, 0);
    tick();
    set_req(2'b01, 401, 41, 6, 0, 0, 0);
    tick();
    set_req(2'b00, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 40 && pulse_q.size() < 2; i++) tick();
    chk_pulse("tmo_first", 0, 400, 40, 5);
    chk_pulse("tmo_second", 1, 401, 41, 6);
    if (pulse_q.size() == 2) chk("tmo_gap", 64'(pulse_q[1].cyc - pulse_q[0].cyc), 9);
    wait_idle(30);
    p_ignore = 1'b0;

    // Reset in WAIT_DONE with three commands queued.
    p_busy_len = 15;
    pulse_q.delete();
    set_req(2'b01, 500, 50, 7, 0, 0, 0);
    tick();
    set_req(2'b00, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && pulse_q.size() < 1; i++) tick();
    chk("rstmid_launch", 64'(pulse_q.size()), 1);
    for (int k = 0; k < 3; k++) begin
      set_req(2'b01, 501 + k, 51 + k, 10 + k, 0, 0, 0);
      tick();
    end
    set_req(2'b00, 0, 0, 0, 0, 0, 0);
    chk("rstmid_queued", fcnt, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_valid", pv, 0);
    chk("rstmid_cmd", {ph, pvc, pr}, 0);
    chk("rstmid_count", fcnt, 0);
    chk("rstmid_busy", busy, 0);
    pulse_q.delete();
    set_req(2'b11, 600, 60, 9, 700, 70, 8);
    #1 chk("rstmid_tie_ready", req_ready, 2'b01);
    tick();
    set_req(2'b00, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 40 && pulse_q.size() < 1; i++) tick();
    chk_pulse("rstmid_fresh", 0, 600, 60, 9);
    for (int i = 0; i < 30; i++) tick();
    chk("rstmid_no_stale", 64'(pulse_q.size()), 1);

    // Drop counter saturation.
    set_req(2'b01, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) tick();
    set_req(2'b00, 0, 0, 0, 0, 0, 0);
    chk("drop_saturate", dcnt, 255);
    chk("drop_not_queued", fcnt, 0);

    // Random traffic against a queue model; pops are taken from the launch pulses.
    begin
      logic       mlast;
      int         mdrop;
      logic [1:0] rv, erdy;
      logic [16:0] ra, rb, rad;
      logic       g0, g1;
      cmd_t       e;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mlast = 1'b1;
      mdrop = 0;
      exp_q.delete();
      for (int c = 0; c < 1500; c++) begin
        if (pv === 1'b1) begin
          if (exp_q.size() == 0) chk("rand_spurious_issue", pv, 0);
          else begin
            e = exp_q.pop_front();
            chk("rand_issue", {ph, pvc, pr}, {e.h, e.v, e.r});
          end
        end
        chk("rand_count", fcnt, 64'(exp_q.size()));
        chk("rand_drop", dcnt, 64'(mdrop));
        p_busy_len = int'($urandom_range(1, 6));
        rv = 2'($urandom_range(0, 3));
        ra = ($urandom_range(0, 9) == 0) ? 17'd0 :
             ($urandom_range(0, 3) == 0) ? 17'($urandom_range(65, 131071)) : 17'($urandom_range(1, 64));
        rb = ($urandom_range(0, 9) == 0) ? 17'd0 :
             ($urandom_range(0, 3) == 0) ? 17'($urandom_range(65, 131071)) : 17'($urandom_range(1, 64));
        set_req(rv, int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)), int'(ra),
                int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)), int'(rb));
        #1;
        g0 = rv[0] && (!rv[1] || mlast == 1'b1);
        g1 = rv[1] && (!rv[0] || mlast == 1'b0);
        erdy = (exp_q.size() >= DEPTH) ? 2'b00 : {g1, g0};
        chk("rand_ready", req_ready, erdy);
        if (erdy != 2'b00) begin
          rad = erdy[1] ? r1 : r0;
          if (rad == 17'd0) begin
            if (mdrop < 255) mdrop++;
          end else begin
            exp_q.push_back('{erdy[1] ? h1 : h0, erdy[1] ? v1 : v0, (rad > 17'd64) ? 17'd64 : rad});
          end
          mlast = erdy[1];
        end
        tick();
      end
      set_req(2'b00, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 200 && !(exp_q.size() == 0 && !busy); i++) begin
        if (pv === 1'b1) begin
          if (exp_q.size() == 0) chk("drain_spurious_issue", pv, 0);
          else begin
            e = exp_q.pop_front();
            chk("rand_issue", {ph, pvc, pr}, {e.h, e.v, e.r});
          end
        end
        tick();
      end
      chk("rand_all_issued", 64'(exp_q.size()), 0);
      chk("rand_final_busy", busy, 0);
    end

    chk("launch_while_painter_busy", 64'(bad_launch), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
